// File: rtl/cache_be_mem_arbiter_pkg.sv
// Shared types for the cache back-end memory arbiter.
// Holds the arbiter state encoding used by the top-level FSM.
package cache_be_mem_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/cache_be_mem_arbiter_rr_priority_pick.sv
// Round-robin picker: first set request after index 'last', wrapping modulo N_REQ.
// Rotates the request vector, priority-encodes the lowest bit, then unrotates the index.
module rr_priority_pick #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic             any,
  output logic [IDX_W-1:0] idx
);

  int               base;
  logic [N_REQ-1:0] req_rot;
  logic [IDX_W-1:0] first_rot;

  assign any = |req;

  // NOTE: every variable gets a value before any condition so no latch is inferred.
  always_comb begin
    base      = (int'(last) + 1) % N_REQ;
    req_rot   = '0;
    first_rot = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_rot[k] = req[IDX_W'((base + k) % N_REQ)];
    end
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_rot[k]) first_rot = IDX_W'(k);
    end
    idx = IDX_W'((int'(first_rot) + base) % N_REQ);
  end

endmodule

// File: rtl/cache_be_mem_arbiter.sv
// Round-robin arbiter sharing one back-end memory port between N_REQ native masters.
// A grant is held while the winner keeps valid high, so multi-beat fills run unbroken.
module cache_be_mem_arbiter
  import cache_be_mem_arbiter_pkg::*;
#(
  parameter int N_REQ  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NBYTES = DATA_W / 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         s_valid,
  input  logic [N_REQ*ADDR_W-1:0]  s_addr,
  input  logic [N_REQ*DATA_W-1:0]  s_wdata,
  input  logic [N_REQ*NBYTES-1:0]  s_wstrb,
  output logic [N_REQ-1:0]         s_ready,
  output logic [DATA_W-1:0]        s_rdata,
  output logic                     mem_valid,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  output logic [NBYTES-1:0]        mem_wstrb,
  input  logic                     mem_ready,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic [N_REQ-1:0]         grant,
  output logic                     busy
);

  localparam int IDX_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic             g_valid;

  rr_priority_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req  (s_valid),
    .last (last_q),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IDX_W'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
    end
  end

  assign g_valid = |(s_valid & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_d = N_REQ'(1) << pick_idx;
          last_d  = pick_idx;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // Dropping valid always releases, even mid-transfer; arbitration restarts next cycle.
        if (!g_valid) begin
          grant_d = '0;
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy      = (state_q == ARB_BUSY);
  assign grant     = grant_q;
  assign mem_valid = busy & g_valid;
  assign s_rdata   = mem_rdata;

  logic [N_REQ-1:0][ADDR_W-1:0] addr_m;
  logic [N_REQ-1:0][DATA_W-1:0] wdata_m;
  logic [N_REQ-1:0][NBYTES-1:0] wstrb_m;

  // Grant is one-hot or zero, so an AND-OR mux yields zero fields whenever idle.
  for (genvar i = 0; i < N_REQ; i++) begin : g_req
    assign addr_m[i]  = grant_q[i] ? s_addr[i*ADDR_W +: ADDR_W]   : '0;
    assign wdata_m[i] = grant_q[i] ? s_wdata[i*DATA_W +: DATA_W]  : '0;
    assign wstrb_m[i] = grant_q[i] ? s_wstrb[i*NBYTES +: NBYTES]  : '0;
    assign s_ready[i] = grant_q[i] & mem_valid & mem_ready;
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    for (int i = 0; i < N_REQ; i++) begin
      mem_addr  = mem_addr  | addr_m[i];
      mem_wdata = mem_wdata | wdata_m[i];
      mem_wstrb = mem_wstrb | wstrb_m[i];
    end
  end

endmodule

// File: tb/tb_cache_be_mem_arbiter.sv
// Self-checking bench: per-cycle vector table on a 2-requester arbiter, a beat scoreboard,
// and hand-written sequences for reset mid-burst and 3-requester wrap-around.
module tb_cache_be_mem_arbiter;

  typedef struct {
    logic        rst;
    logic [1:0]  sv;
    logic        rdy;
    logic [31:0] rdata;
    logic [31:0] a0, a1, d0, d1;
    logic [3:0]  s0, s1;
    logic        ev;
    logic [31:0] ea, ed;
    logic [3:0]  es;
    logic [1:0]  eg, er;
    logic        eb;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [1:0]  ready;
  } beat_t;

  logic        clk;
  logic        reset;
  logic [1:0]  s_valid;
  logic [63:0] s_addr, s_wdata;
  logic [7:0]  s_wstrb;
  logic [1:0]  s_ready;
  logic [31:0] s_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [1:0]  grant;
  logic        busy;

  logic [2:0]  t3_s_valid;
  logic [95:0] t3_s_addr, t3_s_wdata;
  logic [11:0] t3_s_wstrb;
  logic [2:0]  t3_s_ready;
  logic [31:0] t3_s_rdata;
  logic        t3_mem_valid;
  logic [31:0] t3_mem_addr, t3_mem_wdata;
  logic [3:0]  t3_mem_wstrb;
  logic [2:0]  t3_grant;
  logic        t3_busy;

  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vecs[$];
  beat_t sb_q[$];

  cache_be_mem_arbiter #(.N_REQ(2), .ADDR_W(32), .DATA_W(32)) u_dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_ready(s_ready), .s_rdata(s_rdata), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  cache_be_mem_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .s_valid(t3_s_valid), .s_addr(t3_s_addr),
    .s_wdata(t3_s_wdata), .s_wstrb(t3_s_wstrb), .s_ready(t3_s_ready),
    .s_rdata(t3_s_rdata), .mem_valid(t3_mem_valid), .mem_addr(t3_mem_addr),
    .mem_wdata(t3_mem_wdata), .mem_wstrb(t3_mem_wstrb), .mem_ready(1'b0),
    .mem_rdata(32'h0), .grant(t3_grant), .busy(t3_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic [1:0] sv, input logic rdy,
                     input logic [31:0] rdata, input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [3:0] s0,
                     input logic [31:0] d1, input logic [3:0] s1,
                     input logic ev, input logic [31:0] ea, input logic [31:0] ed,
                     input logic [3:0] es, input logic [1:0] eg, input logic [1:0] er,
                     input logic eb);
    vec_t v;
    v.rst = rst; v.sv = sv; v.rdy = rdy; v.rdata = rdata;
    v.a0 = a0; v.a1 = a1; v.d0 = d0; v.s0 = s0; v.d1 = d1; v.s1 = s1;
    v.ev = ev; v.ea = ea; v.ed = ed; v.es = es; v.eg = eg; v.er = er; v.eb = eb;
    vecs.push_back(v);
  endtask

  // Scoreboard: every completed beat must match the oldest expected beat.
  always @(negedge clk) begin
    if (!reset && mem_valid && mem_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_beat: got beat at addr 0x%0h expected no beat", mem_addr);
      end else begin
        beat_t b;
        b = sb_q.pop_front();
        check("sb_addr", 64'(mem_addr), 64'(b.addr));
        check("sb_rdata", 64'(s_rdata), 64'(b.rdata));
        check("sb_s_ready", 64'(s_ready), 64'(b.ready));
      end
    end
  end

  initial begin
    reset = 1'b1; s_valid = '0; s_addr = '0; s_wdata = '0; s_wstrb = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    t3_s_valid = '0; t3_s_addr = '0; t3_s_wdata = '0; t3_s_wstrb = '0;

    // Reset with active inputs: everything quiet.
    add(1, 2'b11, 1, 32'h0, 32'h100, 32'h40, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 0);
    // Single read by req0, ready on the third granted cycle.
    add(0, 2'b01, 0, 32'h0,        32'h100, 32'h0, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b01, 0, 32'h0,        32'h100, 32'h0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b01, 0, 32'h0,        32'h100, 32'h0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b01, 1, 32'hA5A50001, 32'h100, 32'h0, 0, 0, 0, 0, 1, 32'h100, 0, 0, 2'b01, 2'b01, 1);
    add(0, 2'b00, 1, 32'h0,        32'h100, 32'h0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b00, 1, 32'h0,        32'h100, 32'h0, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    // 4-beat line fill by req1 while req0 also waits.
    add(0, 2'b11, 0, 32'h0,        32'h300, 32'h40, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 32'h10000040, 32'h300, 32'h40, 0, 0, 0, 0, 1, 32'h40,  0, 0, 2'b10, 2'b10, 1);
    add(0, 2'b11, 1, 32'h10000044, 32'h300, 32'h44, 0, 0, 0, 0, 1, 32'h44,  0, 0, 2'b10, 2'b10, 1);
    add(0, 2'b11, 1, 32'h10000048, 32'h300, 32'h48, 0, 0, 0, 0, 1, 32'h48,  0, 0, 2'b10, 2'b10, 1);
    add(0, 2'b11, 1, 32'h1000004C, 32'h300, 32'h4C, 0, 0, 0, 0, 1, 32'h4C,  0, 0, 2'b10, 2'b10, 1);
    add(0, 2'b01, 0, 32'h0,        32'h300, 32'h4C, 0, 0, 0, 0, 0, 32'h4C,  0, 0, 2'b10, 2'b00, 1);
    add(0, 2'b01, 0, 32'h0,        32'h300, 32'h4C, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b01, 0, 32'h0,        32'h300, 32'h4C, 0, 0, 0, 0, 1, 32'h300, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b01, 1, 32'h20000300, 32'h300, 32'h4C, 0, 0, 0, 0, 1, 32'h300, 0, 0, 2'b01, 2'b01, 1);
    add(0, 2'b00, 0, 32'h0,        32'h300, 32'h4C, 0, 0, 0, 0, 0, 32'h300, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b00, 0, 32'h0,        32'h300, 32'h4C, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    // Fairness after reset: one beat each, grants alternate 01,10,01,10.
    add(1, 2'b00, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 32'h30000500, 32'h500, 32'h600, 0, 0, 0, 0, 1, 32'h500, 0, 0, 2'b01, 2'b01, 1);
    add(0, 2'b10, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 32'h500, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b11, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 32'h30000600, 32'h500, 32'h600, 0, 0, 0, 0, 1, 32'h600, 0, 0, 2'b10, 2'b10, 1);
    add(0, 2'b01, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 32'h600, 0, 0, 2'b10, 2'b00, 1);
    add(0, 2'b11, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 32'h31000500, 32'h500, 32'h600, 0, 0, 0, 0, 1, 32'h500, 0, 0, 2'b01, 2'b01, 1);
    add(0, 2'b10, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 32'h500, 0, 0, 2'b01, 2'b00, 1);
    add(0, 2'b11, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    add(0, 2'b11, 1, 32'h31000600, 32'h500, 32'h600, 0, 0, 0, 0, 1, 32'h600, 0, 0, 2'b10, 2'b10, 1);
    add(0, 2'b00, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 32'h600, 0, 0, 2'b10, 2'b00, 1);
    add(0, 2'b00, 0, 32'h0,        32'h500, 32'h600, 0, 0, 0, 0, 0, 0,       0, 0, 2'b00, 2'b00, 0);
    // Write pass-through by req0, then req1's write fields once it is granted.
    add(0, 2'b01, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 0, 0,       0,            0,    2'b00, 2'b00, 0);
    add(0, 2'b01, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 1, 32'h200, 32'hDEADBEEF, 4'hF, 2'b01, 2'b00, 1);
    add(0, 2'b11, 1, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 1, 32'h200, 32'hDEADBEEF, 4'hF, 2'b01, 2'b01, 1);
    add(0, 2'b10, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 0, 32'h200, 32'hDEADBEEF, 4'hF, 2'b01, 2'b00, 1);
    add(0, 2'b10, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 0, 0,       0,            0,    2'b00, 2'b00, 0);
    add(0, 2'b10, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 1, 32'h240, 32'h12345678, 4'h3, 2'b10, 2'b00, 1);
    add(0, 2'b00, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 0, 32'h240, 32'h12345678, 4'h3, 2'b10, 2'b00, 1);
    add(0, 2'b00, 0, 32'h0, 32'h200, 32'h240, 32'hDEADBEEF, 4'hF, 32'h12345678, 4'h3, 0, 0,       0,            0,    2'b00, 2'b00, 0);

    @(posedge clk); #1;
    for (int i = 0; i < vecs.size(); i++) begin
      vec_t r;
      r = vecs[i];
      reset = r.rst; s_valid = r.sv; mem_ready = r.rdy; mem_rdata = r.rdata;
      s_addr = {r.a1, r.a0}; s_wdata = {r.d1, r.d0}; s_wstrb = {r.s1, r.s0};
      if (!r.rst && r.ev && r.rdy) sb_q.push_back('{addr: r.ea, rdata: r.rdata, ready: r.er});
      #1;
      check($sformatf("row%0d_mem_valid", i), 64'(mem_valid), 64'(r.ev));
      check($sformatf("row%0d_mem_addr", i),  64'(mem_addr),  64'(r.ea));
      check($sformatf("row%0d_mem_wdata", i), 64'(mem_wdata), 64'(r.ed));
      check($sformatf("row%0d_mem_wstrb", i), 64'(mem_wstrb), 64'(r.es));
      check($sformatf("row%0d_grant", i),     64'(grant),     64'(r.eg));
      check($sformatf("row%0d_s_ready", i),   64'(s_ready),   64'(r.er));
      check($sformatf("row%0d_busy", i),      64'(busy),      64'(r.eb));
      @(posedge clk); #1;
    end

    // Reset asserted mid-burst during beat 2 of a req0 fill.
    s_valid = 2'b01; s_addr = {32'h0, 32'h80}; s_wdata = '0; s_wstrb = '0; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_granted", 64'(grant), 64'(2'b01));
    mem_ready = 1'b1; mem_rdata = 32'h40000080;
    sb_q.push_back('{addr: 32'h80, rdata: 32'h40000080, ready: 2'b01});
    @(posedge clk); #1;
    s_addr = {32'h0, 32'h84}; mem_rdata = 32'h40000084;
    #1;
    check("rst_mid_beat2_ready", 64'(s_ready), 64'(2'b01));
    #1 reset = 1'b1;
    #1;
    check("rst_mid_mem_valid", 64'(mem_valid), 64'(1'b0));
    check("rst_mid_grant", 64'(grant), 64'(2'b00));
    check("rst_mid_busy", 64'(busy), 64'(1'b0));
    check("rst_mid_s_ready", 64'(s_ready), 64'(2'b00));
    s_valid = 2'b11; mem_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_hold_grant", 64'(grant), 64'(2'b00));
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_after_first_grant", 64'(grant), 64'(2'b01));
    check("rst_after_mem_addr", 64'(mem_addr), 64'(32'h84));
    s_valid = 2'b00;
    @(posedge clk); #1;
    check("rst_after_idle", 64'(busy), 64'(1'b0));

    // Wrap-around on the 3-requester instance: reset leaves last=2.
    t3_s_addr = {32'h3000, 32'h2000, 32'h1000}; t3_s_valid = 3'b101;
    #1;
    check("wrap_idle_grant", 64'(t3_grant), 64'(3'b000));
    @(posedge clk); #1;
    check("wrap_first_grant", 64'(t3_grant), 64'(3'b001));
    check("wrap_first_addr", 64'(t3_mem_addr), 64'(32'h1000));
    check("wrap_first_busy", 64'(t3_busy), 64'(1'b1));
    t3_s_valid = 3'b100;
    #1;
    check("wrap_release_valid", 64'(t3_mem_valid), 64'(1'b0));
    @(posedge clk); #1;
    check("wrap_idle2_grant", 64'(t3_grant), 64'(3'b000));
    @(posedge clk); #1;
    check("wrap_second_grant", 64'(t3_grant), 64'(3'b100));
    check("wrap_second_addr", 64'(t3_mem_addr), 64'(32'h3000));
    check("wrap_second_valid", 64'(t3_mem_valid), 64'(1'b1));
    t3_s_valid = 3'b000;
    @(posedge clk); #1;

    check("sb_all_beats_seen", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
